uc_mem_streamer: RTL and testbench
==================================

Name: uc_mem_streamer

Overview:
- Memory-side transmitter for the unit-clause arbiter's initial-load channel.
- On a controller start, it reads a contiguous run of unit-clause literals from the clause memory's request/response read port.
- It streams each literal to the arbiter as mem2uca / mem2uca_valid and flags the final literal with mem2uca_done.
- The arbiter has no back-pressure on this channel, so this block bounds each burst to the arbiter queue depth.

Parameters:
- ADDR_W, 16, width of the clause-memory word address.
- CNT_W, 8, width of the literal count for one burst.
- UCQ_DEPTH, 16, arbiter unit-clause queue depth; the maximum legal burst count.
- MAX_OUTSTANDING, 4, maximum number of granted reads still awaiting a response.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from the controller to begin a burst.
- start_base  in  ADDR_W  first literal address.
- start_count  in  CNT_W  number of literals to send; 0 is legal.
- busy  out  1  high from an accepted start until the cycle after done is driven.
- err  out  1  one-cycle pulse; start rejected or zero literal read.
- uca_stall  in  1  arbiter stall output; high means the arbiter is in IDLE with no valid input.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  read address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  in-order read response valid.
- mem_rdata  in  lit_t  response literal.
- mem2uca_valid  out  1  literal valid to the arbiter.
- mem2uca  out  lit_t  literal to the arbiter.
- mem2uca_done  out  1  burst-complete marker to the arbiter.

Behaviour:
- Reset values:
  - All outputs are 0 and the state is SIDLE.
  - All counters are cleared.
  - Reset mid-burst abandons it; responses arriving after reset deasserts are discarded while in SIDLE.
- States: SIDLE, SFETCH, SDRAIN, SEMPTY.
- Start acceptance in SIDLE:
  - A start is accepted only if uca_stall=1 and start_count<=UCQ_DEPTH.
  - Otherwise err pulses for 1 cycle and the state stays SIDLE.
  - A start while busy=1 is ignored silently.
- On acceptance:
  - The block latches base and count and clears the issued and received counters.
  - count=0 goes to SEMPTY.
  - Any other count goes to SFETCH.
- SEMPTY: drive mem2uca_done=1 with mem2uca_valid=0 for exactly 1 cycle, then go to SIDLE.
- SFETCH request rules:
  - mem_req=1 when outstanding<MAX_OUTSTANDING.
  - mem_addr = base + issued, wrapping modulo 2^ADDR_W.
  - mem_req and mem_addr stay stable until mem_gnt.
- SFETCH grant and exit:
  - On mem_req&&mem_gnt, issued increments.
  - When the grant completes issued==count, go to SDRAIN.
  - outstanding = issued - received; simultaneous grant and response leave it unchanged.
- Response path (SFETCH and SDRAIN):
  - Each mem_rvalid is registered: next cycle mem2uca_valid=1 and mem2uca=mem_rdata.
  - received increments on each response.
  - Latency from mem_rvalid to mem2uca_valid is exactly 1 cycle.
  - Back-to-back responses produce back-to-back valids.
- Done:
  - mem2uca_done=1 in the same cycle as the valid of the count-th literal, never separately for count>0.
  - The state returns to SIDLE after that cycle, and busy drops the following cycle.
- Zero literal: mem_rdata==0 (illegal literal) is still forwarded and err pulses with it; the burst is not aborted.
- A mem_rvalid with no outstanding read is ignored.
- uca_stall is not checked after start; the arbiter stays in IDLE until done by construction.

Decomposition:
- Shared package:
  - lit_t and `LIT_IDX_MAX (existing).
  - New enum uc_str_t {SIDLE, SFETCH, SDRAIN, SEMPTY}.
- No sub-module; the address and outstanding counters and the output register are inline.

Test Plan:
- Basic burst:
  - Stimulus: uca_stall=1, start base=0x10 count=3; memory returns 5,-7,9 with 1-cycle latency and gnt always high.
  - Required: mem_addr sequence 0x10,0x11,0x12; mem2uca_valid on 3 consecutive cycles with 5,-7,9; done only with 9; busy low 1 cycle later.
- Empty burst:
  - Stimulus: start count=0 with uca_stall=1.
  - Required: exactly one cycle of done=1, valid=0; no mem_req; busy high for 2 cycles total.
- Rejects:
  - Stimulus: start count=17 (UCQ_DEPTH=16), then a separate start with uca_stall=0.
  - Required: err pulses each time; no mem_req; busy stays 0.
- Stalled grants and outstanding limit:
  - Stimulus: count=8; gnt low 3 cycles at a time; responses delayed 6 cycles.
  - Required: mem_addr held stable while ungranted; outstanding never exceeds 4; all 8 literals in address order; done with the 8th.
- Address wrap:
  - Stimulus: base=0xFFFE, count=4.
  - Required: addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- Reset mid-burst and zero literal:
  - Stimulus: assert rst after 2 of 5 literals.
  - Required: outputs zero immediately; later rvalids produce no mem2uca_valid; the next start works normally.
  - Stimulus: a response of 0.
  - Required: forwarded with a coincident err pulse.

Source files
------------

// File: rtl/uc_mem_streamer_pkg.sv
// rtl/uc_mem_streamer_pkg.sv - literal type and streamer state encoding shared by the load channel
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 31
`endif

package uc_mem_streamer_pkg;

  typedef logic signed [`LIT_IDX_MAX:0] lit_t;

  typedef enum logic [1:0] {SIDLE, SFETCH, SDRAIN, SEMPTY} uc_str_t;

endpackage

// File: rtl/uc_mem_streamer.sv
// rtl/uc_mem_streamer.sv - reads a run of unit-clause literals from clause memory and streams them to the arbiter
module uc_mem_streamer
  import uc_mem_streamer_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int CNT_W           = 8,
  parameter int UCQ_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [CNT_W-1:0]  start_count,
  output logic              busy,
  output logic              err,
  input  logic              uca_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  lit_t              mem_rdata,
  output logic              mem2uca_valid,
  output lit_t              mem2uca,
  output logic              mem2uca_done
);

  localparam logic [CNT_W-1:0] DEPTH_Q = CNT_W'(UCQ_DEPTH);
  localparam logic [CNT_W-1:0] MAXO_Q  = CNT_W'(MAX_OUTSTANDING);

  uc_str_t           state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  received;

  logic              grant;
  logic              resp_ok;
  logic [CNT_W-1:0]  issued_n;
  logic [CNT_W-1:0]  received_n;
  logic [CNT_W-1:0]  outstanding_n;

  // A response only counts while a burst owns the port and a read is actually in flight.
  always_comb begin
    grant         = mem_req && mem_gnt;
    resp_ok       = mem_rvalid && (state == SFETCH || state == SDRAIN) && (issued != received);
    issued_n      = issued + CNT_W'(grant);
    received_n    = received + CNT_W'(resp_ok);
    outstanding_n = issued_n - received_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SIDLE;
      base_q        <= '0;
      count_q       <= '0;
      issued        <= '0;
      received      <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem2uca_valid <= 1'b0;
      mem2uca       <= '0;
      mem2uca_done  <= 1'b0;
    end else begin
      err           <= 1'b0;
      mem2uca_valid <= 1'b0;
      mem2uca_done  <= 1'b0;

      if (resp_ok) begin
        mem2uca_valid <= 1'b1;
        mem2uca       <= mem_rdata;
        err           <= (mem_rdata == '0);
        mem2uca_done  <= (received_n == count_q);
      end

      case (state)
        SIDLE: begin
          mem_req <= 1'b0;
          // busy lingers one cycle past done; starts seen during that cycle are dropped
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            if (uca_stall && start_count <= DEPTH_Q) begin
              busy     <= 1'b1;
              base_q   <= start_base;
              count_q  <= start_count;
              issued   <= '0;
              received <= '0;
              if (start_count == '0) begin
                state <= SEMPTY;
              end else begin
                state    <= SFETCH;
                mem_req  <= 1'b1;
                mem_addr <= start_base;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end

        SEMPTY: begin
          mem2uca_done <= 1'b1;
          state        <= SIDLE;
        end

        SFETCH, SDRAIN: begin
          issued   <= issued_n;
          received <= received_n;
          if (resp_ok && received_n == count_q) begin
            state   <= SIDLE;
            mem_req <= 1'b0;
          end else if (state == SFETCH) begin
            if (issued_n == count_q) begin
              state   <= SDRAIN;
              mem_req <= 1'b0;
            end else begin
              // address only advances on a grant, so an ungranted request holds steady
              mem_req  <= (outstanding_n < MAXO_Q);
              mem_addr <= base_q + ADDR_W'(issued_n);
            end
          end
        end

        default: state <= SIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_mem_streamer.sv
// tb/tb_uc_mem_streamer.sv - directed bench for uc_mem_streamer with a transaction-level model and memory responder
module tb_uc_mem_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_base = '0;
  logic [7:0]  start_count = '0;
  logic        busy, err;
  logic        uca_stall = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem2uca_valid;
  logic [31:0] mem2uca;
  logic        mem2uca_done;

  uc_mem_streamer dut (
    .clk(clk), .rst(rst), .start(start), .start_base(start_base), .start_count(start_count),
    .busy(busy), .err(err), .uca_stall(uca_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem2uca_valid(mem2uca_valid), .mem2uca(mem2uca), .mem2uca_done(mem2uca_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int mem_tbl [int];
  function automatic int mem_lit(input int a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return a + 1000;
  endfunction

  // memory responder
  int gnt_mode = 0;
  int mem_lat = 1;
  int rq_due[$];
  int rq_dat[$];
  int cyc = 0;

  // transaction-level model
  bit m_busy = 0, m_active = 0, m_empty_pending = 0, m_done_prev = 0;
  int m_base = 0, m_cnt = 0, m_ngnt = 0, m_nresp = 0, m_max_out = 0;
  bit p_start = 0, p_stall = 0, p_gnt = 0, p_rvalid = 0, p_req = 0, p_rst = 1;
  int p_base = 0, p_cnt = 0, p_rdata = 0, p_addr = 0;
  bit grant, resp, accept, reject, e_done, e_err, e_busy;
  int out_n;

  int cap_data[$];
  int cap_addr[$];
  int cap_done[$];
  int n_busy = 0, n_done = 0, n_req = 0, n_err = 0, n_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || p_rst) begin
        if (rst) begin
          check("rst_busy", longint'(busy), 0);
          check("rst_req", longint'(mem_req), 0);
          check("rst_valid", longint'(mem2uca_valid), 0);
          check("rst_done", longint'(mem2uca_done), 0);
        end
        m_busy = 0; m_active = 0; m_empty_pending = 0; m_done_prev = 0;
        m_ngnt = 0; m_nresp = 0;
      end else begin
        n_busy  += int'(busy);
        n_done  += int'(mem2uca_done);
        n_req   += int'(mem_req);
        n_err   += int'(err);
        n_valid += int'(mem2uca_valid);

        grant  = p_req && p_gnt;
        resp   = p_rvalid && m_active && (m_ngnt > m_nresp);
        accept = p_start && !m_busy && p_stall && (p_cnt <= 16);
        reject = p_start && !m_busy && !accept;
        e_done = m_empty_pending || (resp && (m_nresp + 1 == m_cnt));
        e_err  = reject || (resp && p_rdata == 0);
        e_busy = accept ? 1'b1 : (m_done_prev ? 1'b0 : m_busy);

        check("valid", longint'(mem2uca_valid), longint'(resp));
        check("done", longint'(mem2uca_done), longint'(e_done));
        check("err", longint'(err), longint'(e_err));
        check("busy", longint'(busy), longint'(e_busy));
        if (resp) begin
          check("lit", longint'($signed(mem2uca)), longint'(mem_lit((m_base + m_nresp) & 16'hFFFF)));
          cap_data.push_back(int'($signed(mem2uca)));
        end
        if (mem2uca_done) cap_done.push_back(mem2uca_valid ? cap_data.size() : 0);

        if (grant) m_ngnt++;
        if (resp) m_nresp++;
        if (resp && m_nresp == m_cnt) m_active = 0;
        m_empty_pending = 0;
        m_done_prev = e_done;
        m_busy = e_busy;
        if (accept) begin
          m_base = p_base; m_cnt = p_cnt; m_ngnt = 0; m_nresp = 0;
          m_active = (p_cnt != 0);
          m_empty_pending = (p_cnt == 0);
        end

        out_n = m_ngnt - m_nresp;
        if (out_n > m_max_out) m_max_out = out_n;
        if (mem_req) begin
          check("req_allowed", longint'(m_active && m_ngnt < m_cnt && out_n < 4), 1);
          check("req_addr", longint'(mem_addr), longint'((m_base + m_ngnt) & 16'hFFFF));
        end
        if (p_req && !p_gnt) begin
          check("req_held", longint'(mem_req), 1);
          check("addr_held", longint'(mem_addr), longint'(p_addr));
        end
      end

      p_rst = rst;
      mem_gnt = (gnt_mode == 0) ? 1'b1 : ((cyc % 4) == 3);
      if (mem_req && mem_gnt && !rst) begin
        rq_due.push_back(cyc + mem_lat);
        rq_dat.push_back(mem_lit(int'(mem_addr)));
        cap_addr.push_back(int'(mem_addr));
      end
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rq_dat.pop_front();
        void'(rq_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      p_start = start; p_stall = uca_stall; p_base = int'(start_base); p_cnt = int'(start_count);
      p_gnt = mem_gnt; p_rvalid = mem_rvalid; p_rdata = int'(mem_rdata);
      p_req = mem_req; p_addr = int'(mem_addr);
    end
  end

  task automatic clear_caps();
    cap_data.delete(); cap_addr.delete(); cap_done.delete();
    n_busy = 0; n_done = 0; n_req = 0; n_err = 0; n_valid = 0; m_max_out = 0;
  endtask

  task automatic do_start(input int base, input int cnt, input bit stall);
    @(posedge clk); #2;
    start = 1'b1; start_base = 16'(base); start_count = 8'(cnt); uca_stall = stall;
    @(posedge clk); #2;
    start = 1'b0; uca_stall = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while ((m_busy || m_empty_pending || rq_due.size() > 0) && n < 400);
    check({name, "_timeout"}, longint'(n < 400), 1);
    repeat (2) begin @(posedge clk); #2; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int exp_addr[4];
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    check("reset_busy", longint'(busy), 0);
    check("reset_req", longint'(mem_req), 0);
    check("reset_valid", longint'(mem2uca_valid), 0);
    check("reset_done", longint'(mem2uca_done), 0);
    check("reset_err", longint'(err), 0);

    // basic burst
    mem_tbl[16'h10] = 5; mem_tbl[16'h11] = -7; mem_tbl[16'h12] = 9;
    clear_caps();
    do_start(16'h10, 3, 1'b1);
    wait_idle("basic");
    check("basic_ngrant", cap_addr.size(), 3);
    if (cap_addr.size() == 3) begin
      check("basic_a0", cap_addr[0], 16'h10);
      check("basic_a1", cap_addr[1], 16'h11);
      check("basic_a2", cap_addr[2], 16'h12);
    end
    check("basic_nlit", cap_data.size(), 3);
    if (cap_data.size() == 3) begin
      check("basic_l0", cap_data[0], 5);
      check("basic_l1", cap_data[1], -7);
      check("basic_l2", cap_data[2], 9);
    end
    check("basic_ndone", cap_done.size(), 1);
    if (cap_done.size() == 1) check("basic_done_at", cap_done[0], 3);
    check("basic_valid_cycles", n_valid, 3);
    check("basic_busy_cycles", n_busy, 5);

    // empty burst
    clear_caps();
    do_start(16'h50, 0, 1'b1);
    wait_idle("empty");
    check("empty_done_cycles", n_done, 1);
    check("empty_valid_cycles", n_valid, 0);
    check("empty_req_cycles", n_req, 0);
    check("empty_busy_cycles", n_busy, 2);

    // rejects
    clear_caps();
    do_start(16'h60, 17, 1'b1);
    wait_idle("rej_count");
    do_start(16'h60, 2, 1'b0);
    wait_idle("rej_stall");
    check("rej_err_cycles", n_err, 2);
    check("rej_req_cycles", n_req, 0);
    check("rej_busy_cycles", n_busy, 0);

    // largest legal burst fills the outstanding window
    clear_caps();
    mem_lat = 6;
    do_start(16'h100, 16, 1'b1);
    wait_idle("full");
    check("full_nlit", cap_data.size(), 16);
    check("full_max_out", m_max_out, 4);
    if (cap_done.size() == 1) check("full_done_at", cap_done[0], 16);
    else check("full_ndone", cap_done.size(), 1);

    // stalled grants
    clear_caps();
    gnt_mode = 1;
    do_start(16'h30, 8, 1'b1);
    wait_idle("stall");
    check("stall_nlit", cap_data.size(), 8);
    for (int i = 0; i < cap_addr.size() && i < 8; i++) check("stall_addr", cap_addr[i], 16'h30 + i);
    for (int i = 0; i < cap_data.size() && i < 8; i++) check("stall_lit", cap_data[i], 16'h30 + i + 1000);
    if (cap_done.size() == 1) check("stall_done_at", cap_done[0], 8);
    else check("stall_ndone", cap_done.size(), 1);
    check("stall_max_out_le4", longint'(m_max_out <= 4), 1);

    // address wrap
    clear_caps();
    gnt_mode = 0; mem_lat = 1;
    do_start(16'hFFFE, 4, 1'b1);
    wait_idle("wrap");
    exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check("wrap_ngrant", cap_addr.size(), 4);
    for (int i = 0; i < cap_addr.size() && i < 4; i++) check("wrap_addr", cap_addr[i], exp_addr[i]);
    check("wrap_nlit", cap_data.size(), 4);

    // reset mid-burst
    clear_caps();
    mem_lat = 6;
    do_start(16'h20, 5, 1'b1);
    n = 0;
    while (cap_data.size() < 2 && n < 200) begin @(posedge clk); #2; n++; end
    check("midrst_reach2", longint'(cap_data.size()), 2);
    rst = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_req", longint'(mem_req), 0);
    check("midrst_valid", longint'(mem2uca_valid), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n_valid = 0;
    n = 0;
    while (rq_due.size() > 0 && n < 50) begin @(posedge clk); #2; n++; end
    check("midrst_stale_seen", longint'(n > 0), 1);
    repeat (3) begin @(posedge clk); #2; end
    check("midrst_stale_valid", n_valid, 0);

    // restart after reset, with a zero literal mid-burst
    clear_caps();
    mem_lat = 1;
    mem_tbl[16'h41] = 0;
    do_start(16'h40, 3, 1'b1);
    wait_idle("zero");
    check("zero_nlit", cap_data.size(), 3);
    if (cap_data.size() == 3) begin
      check("zero_l0", cap_data[0], 16'h40 + 1000);
      check("zero_l1", cap_data[1], 0);
      check("zero_l2", cap_data[2], 16'h42 + 1000);
    end
    check("zero_err_cycles", n_err, 1);
    if (cap_done.size() == 1) check("zero_done_at", cap_done[0], 3);
    else check("zero_ndone", cap_done.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
